// File: rtl/mult_pipe_pkg.sv
// Shared constants and helpers for the pipelined handshake multiplier.
// Counter width and the product-width rule live here so all files agree.
package mult_pipe_pkg;

  localparam int CNT_W = 32;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/mult_pipe_hs_wrapper_if.sv
// Operand/result handshake bundle for mult_pipe_hs_wrapper.
// master = producer/consumer environment, slave = the multiplier wrapper.
interface mult_pipe_hs_wrapper_if
  import mult_pipe_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic                       in_valid;
  logic                       in_ready;
  logic                       is_signed;
  logic [WIDTH-1:0]           multiplicand;
  logic [WIDTH-1:0]           multiplier;
  logic                       out_valid;
  logic                       out_ready;
  logic [prod_w(WIDTH)-1:0]   product;

  modport master (
    output in_valid,
    output is_signed,
    output multiplicand,
    output multiplier,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  product
  );

  modport slave (
    input  in_valid,
    input  is_signed,
    input  multiplicand,
    input  multiplier,
    input  out_ready,
    output in_ready,
    output out_valid,
    output product
  );

endinterface

// File: rtl/mult_pipe_core.sv
// Combinational WIDTH x WIDTH multiplier, signed or unsigned per operand pair.
// Operands are extended to the full product width so the low half is exact mod 2^(2*WIDTH).
module mult_pipe_core
  import mult_pipe_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                     is_signed,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic [prod_w(WIDTH)-1:0] product
);

  localparam int PW = prod_w(WIDTH);

  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;

  always_comb begin
    a_ext   = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
    b_ext   = {{WIDTH{is_signed & b[WIDTH-1]}}, b};
    product = a_ext * b_ext;
  end

endmodule

// File: rtl/mult_pipe_hs_wrapper.sv
// Registered-I/O pipelined multiplier with valid/ready on both sides, global stall.
// Define MULT_PIPE_PERF_EN to add txn_count/stall_count performance counters.
module mult_pipe_hs_wrapper
  import mult_pipe_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int PIPE_STAGES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  mult_pipe_hs_wrapper_if.slave bus
`ifdef MULT_PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]   txn_count,
  output logic [CNT_W-1:0]   stall_count
`endif
);

  localparam int PW = prod_w(WIDTH);

  typedef struct packed {
    logic          valid;
    logic [PW-1:0] prod;
  } stage_t;

  logic             advance;
  logic             s0_valid;
  logic             s0_signed;
  logic [WIDTH-1:0] s0_a;
  logic [WIDTH-1:0] s0_b;
  logic [PW-1:0]    core_prod;
  stage_t           core_stage;
  stage_t           last_stage;
  logic             out_valid_q;
  logic [PW-1:0]    product_q;

  // Whole pipe moves together; nothing advances while a result waits on the consumer.
  assign advance       = bus.out_ready || !out_valid_q;
  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_valid  <= 1'b0;
      s0_signed <= 1'b0;
      s0_a      <= '0;
      s0_b      <= '0;
    end else if (advance) begin
      s0_valid  <= bus.in_valid;
      s0_signed <= bus.is_signed;
      s0_a      <= bus.multiplicand;
      s0_b      <= bus.multiplier;
    end
  end

  mult_pipe_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .is_signed (s0_signed),
    .a         (s0_a),
    .b         (s0_b),
    .product   (core_prod)
  );

  assign core_stage.valid = s0_valid;
  assign core_stage.prod  = core_prod;

  generate
    if (PIPE_STAGES == 0) begin : g_no_retime
      assign last_stage = core_stage;
    end else begin : g_retime
      for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        stage_t r;
        stage_t src;

        if (k == 0) begin : g_first
          assign src = core_stage;
        end else begin : g_next
          assign src = g_stage[k-1].r;
        end

        always_ff @(posedge clk) begin
          if (!rst_n) begin
            r <= '0;
          end else if (advance) begin
            r <= src;
          end
        end
      end
      assign last_stage = g_stage[PIPE_STAGES-1].r;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      product_q   <= '0;
    end else if (advance) begin
      out_valid_q <= last_stage.valid;
      product_q   <= last_stage.prod;
    end
  end

`ifdef MULT_PIPE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txn_count   <= '0;
      stall_count <= '0;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        txn_count <= txn_count + CNT_W'(1);
      end
      if (out_valid_q && !bus.out_ready) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mult_pipe_hs_wrapper.sv
// Bench for mult_pipe_hs_wrapper: three instances (4b/P1, 8b/P0, 8b/P3) against a
// queue-based arithmetic model plus directed literal vectors.
module tb_mult_pipe_hs_wrapper;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mult_pipe_hs_wrapper_if #(.WIDTH(4)) bus0 ();
  mult_pipe_hs_wrapper_if #(.WIDTH(8)) bus1 ();
  mult_pipe_hs_wrapper_if #(.WIDTH(8)) bus2 ();

`ifdef MULT_PIPE_PERF_EN
  logic [31:0] txn0, stall0, txn1, stall1, txn2, stall2;
`endif

  mult_pipe_hs_wrapper #(.WIDTH(4), .PIPE_STAGES(1)) dut0 (
    .clk (clk), .rst_n (rst_n), .bus (bus0)
`ifdef MULT_PIPE_PERF_EN
    , .txn_count (txn0), .stall_count (stall0)
`endif
  );

  mult_pipe_hs_wrapper #(.WIDTH(8), .PIPE_STAGES(0)) dut1 (
    .clk (clk), .rst_n (rst_n), .bus (bus1)
`ifdef MULT_PIPE_PERF_EN
    , .txn_count (txn1), .stall_count (stall1)
`endif
  );

  mult_pipe_hs_wrapper #(.WIDTH(8), .PIPE_STAGES(3)) dut2 (
    .clk (clk), .rst_n (rst_n), .bus (bus2)
`ifdef MULT_PIPE_PERF_EN
    , .txn_count (txn2), .stall_count (stall2)
`endif
  );

  typedef struct {
    int dut;
    int prod;
    int t;
    int stalls;
  } rec_t;

  rec_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   nc          = 0;
  bit   held   [3];
  int   stalls [3];

  function automatic int dut_w(input int d);
    return (d == 0) ? 4 : 8;
  endfunction

  function automatic int dut_p(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  // Reference arithmetic: interpret operands as integers, multiply, keep 2*w bits.
  function automatic int model_product(input int w, input bit s, input int a, input int b);
    longint av, bv, pr;
    av = a;
    bv = b;
    if (s && a >= (1 << (w - 1))) av = a - (1 << w);
    if (s && b >= (1 << (w - 1))) bv = b - (1 << w);
    pr = av * bv;
    return int'(pr & ((64'd1 << (2 * w)) - 1));
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic get_ov(input int d);
    case (d)
      0:       return bus0.out_valid;
      1:       return bus1.out_valid;
      default: return bus2.out_valid;
    endcase
  endfunction

  function automatic logic get_ir(input int d);
    case (d)
      0:       return bus0.in_ready;
      1:       return bus1.in_ready;
      default: return bus2.in_ready;
    endcase
  endfunction

  function automatic logic [15:0] get_p(input int d);
    case (d)
      0:       return 16'(bus0.product);
      1:       return bus1.product;
      default: return bus2.product;
    endcase
  endfunction

  task automatic apply_stimulus(input int d, input bit iv, input bit s, input int a, input int b, input bit ordy);
    case (d)
      0: begin
        bus0.in_valid = iv; bus0.is_signed = s; bus0.out_ready = ordy;
        bus0.multiplicand = a[3:0]; bus0.multiplier = b[3:0];
      end
      1: begin
        bus1.in_valid = iv; bus1.is_signed = s; bus1.out_ready = ordy;
        bus1.multiplicand = a[7:0]; bus1.multiplier = b[7:0];
      end
      default: begin
        bus2.in_valid = iv; bus2.is_signed = s; bus2.out_ready = ordy;
        bus2.multiplicand = a[7:0]; bus2.multiplier = b[7:0];
      end
    endcase
  endtask

  // Per-cycle scoreboard check for one instance, sampled mid-cycle.
  task automatic mon_dut(input int d, input bit iv, input bit ir, input bit sg, input int a, input int b,
                         input bit ov, input bit ordy, input logic [15:0] p);
    int   idx;
    rec_t r;
    idx = -1;
    check_output($sformatf("dut%0d in_ready", d), 64'(ir), 64'(ordy || !ov));
    if (held[d]) check_output($sformatf("dut%0d held valid", d), 64'(ov), 64'd1);
    if (ov) begin
      for (int i = 0; i < sbq.size(); i++) if (idx < 0 && sbq[i].dut == d) idx = i;
      check_output($sformatf("dut%0d pending txn", d), 64'(idx >= 0), 64'd1);
      if (idx >= 0) begin
        check_output($sformatf("dut%0d product", d), 64'(p), 64'(sbq[idx].prod));
        if (ordy) begin
          check_output($sformatf("dut%0d latency", d), 64'(nc - sbq[idx].t),
                       64'(dut_p(d) + 2 + stalls[d] - sbq[idx].stalls));
          sbq.delete(idx);
        end
      end
    end
    if (ov && !ordy) begin
      held[d] = 1'b1;
      stalls[d]++;
    end else begin
      held[d] = 1'b0;
    end
    if (iv && ir) begin
      r.dut    = d;
      r.prod   = model_product(dut_w(d), sg, a, b);
      r.t      = nc;
      r.stalls = stalls[d];
      sbq.push_back(r);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      for (int i = 0; i < 3; i++) held[i] = 1'b0;
    end else begin
      nc++;
      mon_dut(0, bus0.in_valid, bus0.in_ready, bus0.is_signed, int'(bus0.multiplicand), int'(bus0.multiplier),
              bus0.out_valid, bus0.out_ready, 16'(bus0.product));
      mon_dut(1, bus1.in_valid, bus1.in_ready, bus1.is_signed, int'(bus1.multiplicand), int'(bus1.multiplier),
              bus1.out_valid, bus1.out_ready, bus1.product);
      mon_dut(2, bus2.in_valid, bus2.in_ready, bus2.is_signed, int'(bus2.multiplicand), int'(bus2.multiplier),
              bus2.out_valid, bus2.out_ready, bus2.product);
    end
  end

  // One isolated transaction with out_ready high; checks literal product and latency.
  task automatic run_one(input string name, input int d, input bit s, input int a, input int b,
                         input logic [15:0] exp_p, input int exp_lat);
    bit found;
    int lat;
    found = 1'b0;
    lat   = 0;
    apply_stimulus(d, 1'b1, s, a, b, 1'b1);
    @(negedge clk);
    check_output({name, " in_ready"}, 64'(get_ir(d)), 64'd1);
    @(posedge clk); #1;
    apply_stimulus(d, 1'b0, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (get_ov(d) === 1'b1) begin
        found = 1'b1;
        lat   = i + 1;
      end
    end
    check_output({name, " result seen"}, 64'(found), 64'd1);
    if (found) begin
      check_output({name, " product"}, 64'(get_p(d)), 64'(exp_p));
      check_output({name, " latency"}, 64'(lat), 64'(exp_lat));
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (5000) @(posedge clk);
    $display("[TB] FAIL watchdog: bench did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int first, last, cnt;
    logic [15:0] drain_exp [3];
    drain_exp[0] = 16'h0F;
    drain_exp[1] = 16'hFA;
    drain_exp[2] = 16'h3F;

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      apply_stimulus(d, 1'b0, 1'b0, 0, 0, 1'b1);
      stalls[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check_output($sformatf("reset dut%0d out_valid", d), 64'(get_ov(d)), 64'd0);
      check_output($sformatf("reset dut%0d product", d), 64'(get_p(d)), 64'd0);
      check_output($sformatf("reset dut%0d in_ready", d), 64'(get_ir(d)), 64'd1);
    end
`ifdef MULT_PIPE_PERF_EN
    check_output("reset txn_count", 64'(txn0), 64'd0);
    check_output("reset stall_count", 64'(stall0), 64'd0);
`endif
    @(posedge clk); #1;

    run_one("u 15*15", 0, 1'b0, 15, 15, 16'hE1, 3);
    run_one("s -8*-8", 0, 1'b1, 8, 8, 16'h40, 3);
    run_one("s F*1", 0, 1'b1, 15, 1, 16'hFF, 3);
    run_one("u F*1", 0, 1'b0, 15, 1, 16'h0F, 3);

    first = -1; last = -1; cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (k < 8) apply_stimulus(0, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                                int'($urandom_range(0, 15)), 1'b1);
      else       apply_stimulus(0, 1'b0, 1'b0, 0, 0, 1'b1);
      @(negedge clk);
      if (get_ov(0) === 1'b1) begin
        cnt++;
        if (first < 0) first = k;
        last = k;
      end
      @(posedge clk); #1;
    end
    check_output("burst count", 64'(cnt), 64'd8);
    check_output("burst first", 64'(first), 64'd3);
    check_output("burst span", 64'(last - first), 64'd7);

    do_reset();
    apply_stimulus(0, 1'b1, 1'b0, 3, 5, 1'b0);  @(posedge clk); #1;
    apply_stimulus(0, 1'b1, 1'b1, 14, 3, 1'b0); @(posedge clk); #1;
    apply_stimulus(0, 1'b1, 1'b0, 7, 9, 1'b0);  @(posedge clk); #1;
    apply_stimulus(0, 1'b0, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("stall out_valid", 64'(get_ov(0)), 64'd1);
      check_output("stall product", 64'(get_p(0)), 64'h0F);
      check_output("stall in_ready", 64'(get_ir(0)), 64'd0);
      @(posedge clk); #1;
    end
    apply_stimulus(0, 1'b0, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output($sformatf("drain%0d out_valid", i), 64'(get_ov(0)), 64'd1);
      check_output($sformatf("drain%0d product", i), 64'(get_p(0)), 64'(drain_exp[i]));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_output("drain empty", 64'(get_ov(0)), 64'd0);
`ifdef MULT_PIPE_PERF_EN
    check_output("txn_count", 64'(txn0), 64'd3);
    check_output("stall_count", 64'(stall0), 64'd5);
`endif
    @(posedge clk); #1;

    do_reset();
    apply_stimulus(0, 1'b1, 1'b0, 5, 6, 1'b1); @(posedge clk); #1;
    apply_stimulus(0, 1'b1, 1'b1, 9, 9, 1'b1); @(posedge clk); #1;
    apply_stimulus(0, 1'b0, 1'b0, 0, 0, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_output("midreset out_valid", 64'(get_ov(0)), 64'd0);
    check_output("midreset product", 64'(get_p(0)), 64'd0);
    check_output("midreset in_ready", 64'(get_ir(0)), 64'd1);
`ifdef MULT_PIPE_PERF_EN
    check_output("midreset txn_count", 64'(txn0), 64'd0);
`endif
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_output("no stale result", 64'(get_ov(0)), 64'd0);
    end
    @(posedge clk); #1;

    run_one("P0 s 80*80", 1, 1'b1, 8'h80, 8'h80, 16'h4000, 2);
    run_one("P3 s 80*80", 2, 1'b1, 8'h80, 8'h80, 16'h4000, 5);

    for (int k = 0; k < 40; k++) begin
      for (int d = 0; d < 3; d++) begin
        apply_stimulus(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, (d == 0) ? 15 : 255)),
                       int'($urandom_range(0, (d == 0) ? 15 : 255)),
                       ($urandom_range(0, 3) != 0));
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 3; d++) apply_stimulus(d, 1'b0, 1'b0, 0, 0, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_output("scoreboard drained", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
